instr_sequencer: RTL and testbench

//  Program sequencer feeding the autoencoder datapath: replaces the free-running PC/counter.

---
 rtl/instr_sequencer_pkg.sv | 21 ++
 rtl/instr_sequencer_if.sv | 25 ++
 rtl/instr_sequencer_prog_ram.sv | 23 ++
 rtl/instr_sequencer.sv | 167 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared constants, FSM encoding and field helpers for the
// autoencoder program sequencer.
package instr_sequencer_pkg;

  localparam int INSTR_W = 16;
  localparam logic [3:0] HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  function automatic logic [3:0] opcode(
    input logic [INSTR_W-1:0] w
  );
    return w[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Host program-load handshake: one instruction word per
// valid/ready beat, last marks the final word.
interface instr_sequencer_if;
  import instr_sequencer_pkg::*;

  logic               valid;
  logic               ready;
  logic               last;
  logic [INSTR_W-1:0] data;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/instr_sequencer_prog_ram.sv
// Program store: one write port, one synchronous read port.
// Contents are deliberately not reset.
module instr_sequencer_prog_ram #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: loads a program from the host, then
// issues it one word per cycle for a number of epochs.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int EPOCH_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  instr_sequencer_if.slave   ld,
  input  logic               start,
  input  logic               abort,
  input  logic [EPOCH_W-1:0] epochs,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic               busy,
  output logic               done
);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   pc_d, wr_ptr, wr_ptr_d;
  logic [ADDR_W:0]     prog_len, prog_len_d;
  logic [EPOCH_W-1:0]  tgt, tgt_d, fpass, fpass_d;
  logic [EPOCH_W-1:0]  ec_d, ec_inc;
  logic                fetch_off, foff_d;
  logic                iss_vld, ivld_d;
  logic                iss_last, ilast_d;
  logic                we, accept, wr_end, fetch;
  logic                f_last, f_more, is_halt;
  logic                pass_end, run_end, restart;
  logic [INSTR_W-1:0]  rdata;

  instr_sequencer_prog_ram #(
    .AW (ADDR_W),
    .DW (INSTR_W)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (ld.data),
    .re    (fetch),
    .raddr (pc),
    .rdata (rdata)
  );

  assign ld.ready = (state == S_IDLE)
                 || (state == S_LOAD);
  assign accept = ld.valid && ld.ready;
  assign wr_end = ld.last || (&wr_ptr);

  assign fetch  = (state == S_RUN) && !fetch_off;
  assign f_last = ({1'b0, pc} ==
                   prog_len - (ADDR_W+1)'(1));
  assign f_more = ({1'b0, fpass} + (EPOCH_W+1)'(1))
                  < {1'b0, tgt};

  assign is_halt  = iss_vld
                 && (opcode(rdata) == HALT_OP);
  assign pass_end = iss_vld && (iss_last || is_halt);
  assign ec_inc   = epoch_count + EPOCH_W'(1);
  assign run_end  = pass_end && (ec_inc == tgt);
  assign restart  = is_halt && !run_end;

  // A HALT word is swallowed: it ends the pass without issuing.
  assign instr_valid = iss_vld && !is_halt;
  assign instruction = instr_valid ? rdata : '0;
  assign busy        = (state != S_IDLE);

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    wr_ptr_d   = wr_ptr;
    prog_len_d = prog_len;
    tgt_d      = tgt;
    fpass_d    = fpass;
    foff_d     = fetch_off;
    ivld_d     = 1'b0;
    ilast_d    = 1'b0;
    ec_d       = epoch_count;
    we         = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          we = 1'b1;
          if (wr_end) begin
            prog_len_d = {1'b0, wr_ptr}
                       + (ADDR_W+1)'(1);
            wr_ptr_d   = '0;
            state_d    = S_IDLE;
          end else begin
            wr_ptr_d = wr_ptr + ADDR_W'(1);
            state_d  = S_LOAD;
          end
        end else if (state == S_IDLE && start) begin
          ec_d    = '0;
          tgt_d   = (epochs == '0) ? EPOCH_W'(1)
                                   : epochs;
          pc_d    = '0;
          fpass_d = '0;
          foff_d  = 1'b0;
          state_d = (prog_len != '0) ? S_RUN
                                     : S_DONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (pass_end) ec_d = ec_inc;
          if (run_end) begin
            state_d = S_DONE;
          end else if (restart) begin
            // squash the word behind the HALT
            pc_d    = '0;
            fpass_d = ec_inc;
            foff_d  = 1'b0;
          end else if (fetch) begin
            ivld_d  = 1'b1;
            ilast_d = f_last;
            if (f_last) begin
              fpass_d = fpass + EPOCH_W'(1);
              if (f_more) pc_d = '0;
              else        foff_d = 1'b1;
            end else begin
              pc_d = pc + ADDR_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      wr_ptr      <= '0;
      prog_len    <= '0;
      tgt         <= '0;
      fpass       <= '0;
      fetch_off   <= 1'b0;
      iss_vld     <= 1'b0;
      iss_last    <= 1'b0;
      epoch_count <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      wr_ptr      <= wr_ptr_d;
      prog_len    <= prog_len_d;
      tgt         <= tgt_d;
      fpass       <= fpass_d;
      fetch_off   <= foff_d;
      iss_vld     <= ivld_d;
      iss_last    <= ilast_d;
      epoch_count <= ec_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues the
// expected issue/done cycles, a negedge monitor checks them.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  epochs = 8'd0;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc;
  logic [7:0]  epoch_count;
  logic        busy;
  logic        done;

  instr_sequencer_if ld ();

  instr_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ld          (ld),
    .start       (start),
    .abort       (abort),
    .epochs      (epochs),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .epoch_count (epoch_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] ins;
    logic [7:0]  ec;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] prog[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @cyc %0d",
               nm, act, req, cyc);
    end
  endtask

  // Monitor: every issue and done must match the head of its queue.
  always @(negedge clock) begin
    exp_t e;
    if (instr_valid) begin
      if (iq.size() == 0) begin
        chk("spurious_issue", {16'h0, instruction}, 32'hDEAD);
      end else begin
        e = iq.pop_front();
        chk("issue_cyc", cyc, e.cyc);
        chk("issue_word", {16'h0, instruction}, {16'h0, e.ins});
        chk("issue_ec", {24'h0, epoch_count}, {24'h0, e.ec});
      end
    end else begin
      chk("idle_instr_zero", {16'h0, instruction}, 32'h0);
      if (iq.size() != 0 && iq[0].cyc <= cyc) begin
        e = iq.pop_front();
        chk("missed_issue_cyc", cyc + 1000, e.cyc);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        chk("spurious_done", cyc, 32'hFFFF);
      end else begin
        e = dq.pop_front();
        chk("done_cyc", cyc, e.cyc);
        chk("done_ec", {24'h0, epoch_count}, {24'h0, e.ec});
      end
    end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
      e = dq.pop_front();
      chk("missed_done_cyc", cyc + 1000, e.cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input bit use_last);
    for (int i = 0; i < prog.size(); i++) begin
      ld.valid = 1'b1;
      ld.data  = prog[i];
      ld.last  = use_last && (i == prog.size() - 1);
      chk("load_ready", {31'h0, ld.ready}, 32'h1);
      tick();
    end
    ld.valid = 1'b0;
    ld.last  = 1'b0;
    ld.data  = '0;
  endtask

  task automatic push_iss(input int c, input logic [15:0] w,
                          input logic [7:0] e);
    exp_t x;
    x.cyc = c; x.ins = w; x.ec = e;
    iq.push_back(x);
  endtask

  task automatic push_done(input int c, input logic [7:0] e);
    exp_t x;
    x.cyc = c; x.ins = '0; x.ec = e;
    dq.push_back(x);
  endtask

  task automatic pulse_start(input logic [7:0] ep);
    start  = 1'b1;
    epochs = ep;
    tick();
    start  = 1'b0;
  endtask

  task automatic drain(input string nm);
    chk({nm, "_iq_empty"}, iq.size(), 0);
    chk({nm, "_dq_empty"}, dq.size(), 0);
    chk({nm, "_busy_low"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int t;
    ld.valid = 1'b0;
    ld.last  = 1'b0;
    ld.data  = '0;
    #12;
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", {16'h0, instruction}, 32'h0);
    chk("rst_pc", {27'h0, pc}, 32'h0);
    chk("rst_ec", {24'h0, epoch_count}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_ready", {31'h0, ld.ready}, 32'h1);
    reset_n = 1'b1;
    tick();

    // empty program: start goes straight to done
    t = cyc;
    push_done(t + 1, 8'd0);
    pulse_start(8'd1);
    repeat (3) tick();
    drain("t5_empty");

    // start collides with a load beat: load wins
    ld.valid = 1'b1; ld.data = 16'h4321; ld.last = 1'b1;
    start = 1'b1; epochs = 8'd1;
    tick();
    start = 1'b0; ld.valid = 1'b0; ld.last = 1'b0;
    repeat (4) tick();
    drain("t5_collide");

    // epochs=0 behaves as one pass over the 1-word program
    t = cyc;
    push_iss(t + 2, 16'h4321, 8'd0);
    push_done(t + 3, 8'd1);
    pulse_start(8'd0);
    repeat (4) tick();
    drain("t5_ep0");

    // four-word program, one epoch
    prog = '{16'h1123, 16'h2456, 16'h3789, 16'h0ABC};
    load(1'b1);
    chk("t1_ready_idle", {31'h0, ld.ready}, 32'h1);
    t = cyc;
    for (int k = 0; k < 4; k++) push_iss(t + 2 + k, prog[k], 8'd0);
    push_done(t + 6, 8'd1);
    pulse_start(8'd1);
    chk("t1_ready_run", {31'h0, ld.ready}, 32'h0);
    chk("t1_pc0", {27'h0, pc}, 32'h0);
    repeat (6) tick();
    drain("t1");

    // same program, three back-to-back epochs
    t = cyc;
    for (int k = 0; k < 12; k++)
      push_iss(t + 2 + k, prog[k % 4], 8'(k / 4));
    push_done(t + 14, 8'd3);
    pulse_start(8'd3);
    repeat (15) tick();
    drain("t2");

    // HALT in the middle: 2-cycle bubble, tail never issued
    prog = '{16'h1123, 16'hF000, 16'h2456};
    load(1'b1);
    t = cyc;
    push_iss(t + 2, 16'h1123, 8'd0);
    push_iss(t + 5, 16'h1123, 8'd1);
    push_done(t + 7, 8'd2);
    pulse_start(8'd2);
    repeat (8) tick();
    drain("t3");

    // full 32-word program without load_last
    prog.delete();
    for (int i = 0; i < 32; i++) prog.push_back(16'h1000 + 16'(i * 16'h0101));
    load(1'b0);
    chk("t4_ready_idle", {31'h0, ld.ready}, 32'h1);
    chk("t4_busy_idle", {31'h0, busy}, 32'h0);
    t = cyc;
    for (int k = 0; k < 64; k++)
      push_iss(t + 2 + k, prog[k % 32], 8'(k / 32));
    push_done(t + 66, 8'd2);
    pulse_start(8'd2);
    chk("t4_ready_run", {31'h0, ld.ready}, 32'h0);
    repeat (31) tick();
    chk("t4_pc_end", {27'h0, pc}, 32'd31);
    tick();
    chk("t4_pc_wrap", {27'h0, pc}, 32'd0);
    repeat (34) tick();
    drain("t4");

    // abort on the third issue cycle
    t = cyc;
    for (int k = 0; k < 3; k++) push_iss(t + 2 + k, prog[k], 8'd0);
    pulse_start(8'd2);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_valid", {31'h0, instr_valid}, 32'h0);
    chk("t6_abort_busy", {31'h0, busy}, 32'h0);
    repeat (3) tick();
    drain("t6_abort");

    // asynchronous reset in the middle of a run
    t = cyc;
    for (int k = 0; k < 3; k++) push_iss(t + 2 + k, prog[k], 8'd0);
    pulse_start(8'd3);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("t6_rst_instr", {16'h0, instruction}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy}, 32'h0);
    chk("t6_rst_pc", {27'h0, pc}, 32'h0);
    chk("t6_rst_ec", {24'h0, epoch_count}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    drain("t6_rst");
    t = cyc;
    push_done(t + 1, 8'd0);
    pulse_start(8'd2);
    repeat (3) tick();
    drain("t6_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

endmodule
